// File: rtl/uart_xfer_pkg.sv
// Shared types for the UART frame transfer path: FSM state encoding
// (also shown on the debug LEDs) and byte / edge-detect sizing.
package uart_xfer_pkg;

    localparam int BYTE_W     = 8;
    localparam int EDGE_DEPTH = 2;

    typedef enum logic [2:0] {
        S_SKIP    = 3'd0,
        S_RX      = 3'd1,
        S_RX_DONE = 3'd2,
        S_FETCH   = 3'd3,
        S_LOAD    = 3'd4,
        S_SEND    = 3'd5,
        S_WAITB   = 3'd6,
        S_DONE    = 3'd7
    } state_e;

endpackage

// File: rtl/uart_rx_edge.sv
// Synchronises the UART byte-available level and emits one pulse
// per rising edge, i.e. one pulse per received byte.
module uart_rx_edge
    import uart_xfer_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic evt
);

    logic [EDGE_DEPTH-1:0] sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[EDGE_DEPTH-2:0], level};
        end
    end

    assign evt = sync[EDGE_DEPTH-2] & ~sync[EDGE_DEPTH-1];

endmodule

// File: rtl/uart_frame_xfer_ctrl.sv
// Skips leading rx bytes, stores one frame to memory, then streams it back out.
// Optional RX_CHECKSUM_EN: running rx byte sum checked against the post-frame byte.
module uart_frame_xfer_ctrl
    import uart_xfer_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int FRAME_LEN = 65536,
    parameter int RX_SKIP   = 2,
    parameter int TX_LEN    = 65536
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_ready,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [BYTE_W-1:0] tx_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [BYTE_W-1:0] mem_wdata,
    input  logic [BYTE_W-1:0] mem_rdata,
    input  logic              start_tx,
    output logic              rx_done,
    output logic              tx_done,
`ifdef RX_CHECKSUM_EN
    output logic [BYTE_W-1:0] rx_sum,
    output logic              sum_ok,
`endif
    output logic [2:0]        state_dbg
);

    localparam int CNT_W  = ADDR_W + 1;
    localparam int SKIP_W = $clog2(RX_SKIP + 1) + 1;

    localparam logic [CNT_W-1:0]  WR_LAST   = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]  RD_LAST   = CNT_W'(TX_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'(RX_SKIP - 1);
    localparam logic [SKIP_W-1:0] SKIP_ONE  = SKIP_W'(1);
    localparam state_e RST_STATE = (RX_SKIP == 0) ? S_RX : S_SKIP;

    state_e             state;
    logic               rx_evt;
    logic [CNT_W-1:0]   wr_cnt;
    logic [CNT_W-1:0]   rd_cnt;
    logic [CNT_W-1:0]   rd_nxt;
    logic [SKIP_W-1:0]  skip_cnt;
    logic [1:0]         wait_cnt;
    logic               busy_seen;
`ifdef RX_CHECKSUM_EN
    logic               sum_seen;
`endif

    uart_rx_edge u_rx_edge (
        .clk   (clk),
        .rst   (rst),
        .level (rx_ready),
        .evt   (rx_evt)
    );

    assign rd_nxt    = rd_cnt + CNT_ONE;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RST_STATE;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            skip_cnt  <= '0;
            wait_cnt  <= '0;
            busy_seen <= 1'b0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            rx_done   <= 1'b0;
            tx_done   <= 1'b0;
`ifdef RX_CHECKSUM_EN
            rx_sum    <= '0;
            sum_ok    <= 1'b0;
            sum_seen  <= 1'b0;
`endif
        end else begin
            mem_we   <= 1'b0;
            tx_start <= 1'b0;
            case (state)
                S_SKIP: begin
                    if (rx_evt) begin
                        if (skip_cnt == SKIP_LAST) begin
                            skip_cnt <= '0;
                            state    <= S_RX;
                        end else begin
                            skip_cnt <= skip_cnt + SKIP_ONE;
                        end
                    end
                end
                S_RX: begin
                    if (rx_evt) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= rx_data;
                        mem_addr  <= wr_cnt[ADDR_W-1:0];
                        wr_cnt    <= wr_cnt + CNT_ONE;
`ifdef RX_CHECKSUM_EN
                        rx_sum    <= rx_sum + rx_data;
`endif
                        if (wr_cnt == WR_LAST) begin
                            rx_done <= 1'b1;
                            state   <= S_RX_DONE;
                        end
                    end
                end
                S_RX_DONE: begin
`ifdef RX_CHECKSUM_EN
                    if (rx_evt && !sum_seen) begin
                        sum_seen <= 1'b1;
                        sum_ok   <= (rx_data == rx_sum);
                    end
`endif
                    if (start_tx) begin
                        rd_cnt   <= '0;
                        mem_addr <= '0;
                        state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    mem_addr <= rd_cnt[ADDR_W-1:0];
                    state    <= S_LOAD;
                end
                S_LOAD: begin
                    tx_data <= mem_rdata;
                    state   <= S_SEND;
                end
                S_SEND: begin
                    if (!tx_busy) begin
                        tx_start  <= 1'b1;
                        wait_cnt  <= '0;
                        busy_seen <= 1'b0;
                        state     <= S_WAITB;
                    end
                end
                // UART may never raise busy; give up waiting after two cycles
                S_WAITB: begin
                    if (tx_busy) begin
                        busy_seen <= 1'b1;
                    end else if (busy_seen || wait_cnt == 2'd2) begin
                        if (rd_cnt == RD_LAST) begin
                            tx_done <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            rd_cnt   <= rd_nxt;
                            mem_addr <= rd_nxt[ADDR_W-1:0];
                            state    <= S_FETCH;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                default: begin
                    state <= RST_STATE;
                end
            endcase
        end
    end

endmodule
